// File: rtl/alu_wb_protocol_monitor.sv
// Writeback-protocol monitor for NUM_CH ALU pipelines.
// Passive observer: tracks in-order issue/writeback per channel, checks PR
// matching, latency bounds and post-reset values, and captures the first error.
// Sticky error bit k of channel c is err_sticky[c*5+k]:
//   0 reset-value violation, 1 spurious WB, 2 overflow, 3 timeout, 4 PR mismatch.
// Handshake: an issue is accepted on a CLK edge where issue_valid & issue_ready;
// a writeback is presented on a CLK edge where WB_valid is high (no back-pressure).
module alu_wb_protocol_monitor #(
    parameter int NUM_CH       = 2,
    parameter int LOG_PR_COUNT = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int MAX_LAT      = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic [NUM_CH-1:0]                             issue_valid,
    input  logic [NUM_CH-1:0]                             issue_ready,
    input  logic [NUM_CH*LOG_PR_COUNT-1:0]                issue_PR,
    input  logic [NUM_CH-1:0]                             WB_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                  WB_data,
    input  logic [NUM_CH*LOG_PR_COUNT-1:0]                WB_PR,
    output logic [NUM_CH*5-1:0]                           err_sticky,
    output logic                                          first_err_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch,
    output logic [2:0]                                    first_err_code,
    output logic [CNT_WIDTH-1:0]                          first_err_cycle,
    output logic [CNT_WIDTH-1:0]                          wb_pass_count
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam logic [PW:0]          FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAT_LIM  = CNT_WIDTH'(MAX_LAT);

    // Per-channel FIFO of {PR, accept cycle}
    logic [LOG_PR_COUNT-1:0] r_pr   [NUM_CH][DEPTH];
    logic [CNT_WIDTH-1:0]    r_ts   [NUM_CH][DEPTH];
    logic [PW-1:0]           r_wptr [NUM_CH];
    logic [PW-1:0]           r_rptr [NUM_CH];
    logic [PW:0]             r_cnt  [NUM_CH];
    logic [4:0]              r_sticky [NUM_CH];

    logic                    r_armed;
    logic [CNT_WIDTH-1:0]    r_cycle;
    logic [CNT_WIDTH-1:0]    r_pass;
    logic                    r_fe_valid;
    logic [CH_W-1:0]         r_fe_ch;
    logic [2:0]              r_fe_code;
    logic [CNT_WIDTH-1:0]    r_fe_cycle;

    logic                    w_acc   [NUM_CH];
    logic                    w_pop   [NUM_CH];
    logic                    w_full  [NUM_CH];
    logic [LOG_PR_COUNT-1:0] w_head_pr [NUM_CH];
    logic [CNT_WIDTH-1:0]    w_age   [NUM_CH];
    logic                    w_push  [NUM_CH];
    logic                    w_match [NUM_CH];
    logic [4:0]              w_set   [NUM_CH];
    logic [4:0]              w_new   [NUM_CH];
    logic                    w_any_new;
    logic [CH_W-1:0]         w_fe_ch;
    logic [2:0]              w_fe_code;
    logic [CNT_WIDTH-1:0]    w_pass_next;

    // Per-channel FIFO status and handshake decode
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_acc[c]     = issue_valid[c] & issue_ready[c];
            w_pop[c]     = WB_valid[c] & (r_cnt[c] != '0);
            w_full[c]    = (r_cnt[c] == FULL_CNT);
            w_head_pr[c] = r_pr[c][r_rptr[c]];
            w_age[c]     = r_cycle - r_ts[c][r_rptr[c]];
        end
    end

    // Per-channel push decision and error detection for this edge
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // A full FIFO still accepts when the head leaves on the same edge
            w_push[c]  = w_acc[c] & (~w_full[c] | w_pop[c]);
            w_match[c] = w_pop[c] & (WB_PR[c*LOG_PR_COUNT +: LOG_PR_COUNT] == w_head_pr[c]);
            w_set[c][0] = r_armed & (~issue_ready[c] | WB_valid[c]
                                     | (WB_data[c*DATA_WIDTH +: DATA_WIDTH] != '0)
                                     | (WB_PR[c*LOG_PR_COUNT +: LOG_PR_COUNT] != '0));
            w_set[c][1] = WB_valid[c] & (r_cnt[c] == '0);
            w_set[c][2] = w_acc[c] & w_full[c] & ~w_pop[c];
            w_set[c][3] = (r_cnt[c] != '0) & ~w_pop[c] & (w_age[c] > LAT_LIM);
            w_set[c][4] = w_pop[c] & ~w_match[c];
            w_new[c]    = w_set[c] & ~r_sticky[c];
        end
    end

    // Lowest channel / lowest bit among newly set errors, and saturating pass count
    always_comb begin
        w_any_new   = 1'b0;
        w_fe_ch     = '0;
        w_fe_code   = '0;
        w_pass_next = r_pass;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_new[c] != '0) begin
                w_any_new = 1'b1;
                w_fe_ch   = CH_W'(c);
                for (int k = 4; k >= 0; k--) begin
                    if (w_new[c][k]) w_fe_code = 3'(k);
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_match[c] && (w_pass_next != '1)) w_pass_next = w_pass_next + 1'b1;
        end
    end

    // State update: FIFOs, sticky flags, counters and first-error capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_armed    <= 1'b1;
            r_cycle    <= '0;
            r_pass     <= '0;
            r_fe_valid <= 1'b0;
            r_fe_ch    <= '0;
            r_fe_code  <= '0;
            r_fe_cycle <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c]   <= '0;
                r_rptr[c]   <= '0;
                r_cnt[c]    <= '0;
                r_sticky[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_pr[c][d] <= '0;
                    r_ts[c][d] <= '0;
                end
            end
        end else begin
            r_armed <= 1'b0;
            r_cycle <= r_cycle + 1'b1;
            r_pass  <= w_pass_next;
            for (int c = 0; c < NUM_CH; c++) begin
                r_sticky[c] <= r_sticky[c] | w_set[c];
                if (w_push[c]) begin
                    r_pr[c][r_wptr[c]] <= issue_PR[c*LOG_PR_COUNT +: LOG_PR_COUNT];
                    r_ts[c][r_wptr[c]] <= r_cycle;
                    r_wptr[c]          <= r_wptr[c] + 1'b1;
                end
                if (w_pop[c]) r_rptr[c] <= r_rptr[c] + 1'b1;
                if (w_push[c] && !w_pop[c])      r_cnt[c] <= r_cnt[c] + 1'b1;
                else if (!w_push[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - 1'b1;
            end
            if (!r_fe_valid && w_any_new) begin
                r_fe_valid <= 1'b1;
                r_fe_ch    <= w_fe_ch;
                r_fe_code  <= w_fe_code;
                r_fe_cycle <= r_cycle;
            end
        end
    end

    // Flatten sticky flags onto the output bus
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            err_sticky[c*5 +: 5] = r_sticky[c];
        end
    end

    assign first_err_valid = r_fe_valid;
    assign first_err_ch    = r_fe_ch;
    assign first_err_code  = r_fe_code;
    assign first_err_cycle = r_fe_cycle;
    assign wb_pass_count   = r_pass;

endmodule
